// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param_if
//  Brief    : Read/write/debug/dump signal bundle for reg_file_param.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_file_param_if #(
   parameter int N = 16,
   parameter int M = 3
);
   logic [M-1:0] Reg_read_ad_1;
   logic [M-1:0] Reg_read_ad_2;
   logic [N-1:0] Reg_read_data_1;
   logic [N-1:0] Reg_read_data_2;
   logic         Reg_Write;
   logic [M-1:0] Reg_write_ad;
   logic [N-1:0] Reg_write_data;
   logic         inr_check;
   logic [M-1:0] inr;
   logic [N-1:0] outvalue;
   logic         dump_start;
   logic         dump_busy;
   logic         dump_valid;
   logic         dump_ready;
   logic [M-1:0] dump_addr;
   logic [N-1:0] dump_data;

   modport master (
      output Reg_read_ad_1, Reg_read_ad_2, Reg_Write, Reg_write_ad, Reg_write_data,
      output inr_check, inr, dump_start, dump_ready,
      input  Reg_read_data_1, Reg_read_data_2, outvalue,
      input  dump_busy, dump_valid, dump_addr, dump_data
   );

   modport slave (
      input  Reg_read_ad_1, Reg_read_ad_2, Reg_Write, Reg_write_ad, Reg_write_data,
      input  inr_check, inr, dump_start, dump_ready,
      output Reg_read_data_1, Reg_read_data_2, outvalue,
      output dump_busy, dump_valid, dump_addr, dump_data
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param
//  Brief    : N x 2**M register file, 2 comb read ports, 1 write port,
//             optional bypass, debug sample and handshaked dump engine.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_param #(
   parameter int N      = 16,
   parameter int M      = 3,
   parameter int BYPASS = 1,
   parameter int INIT0  = 7,
   parameter int INIT1  = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   reg_file_param_if.slave  bus
);
   localparam int DEPTH = 2 ** M;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [N-1:0] regs_q [DEPTH];
   logic [N-1:0] outvalue_q;
   logic [0:0]   state_q, state_d;
   logic [M-1:0] addr_q, addr_d;
   logic [N-1:0] data_q, data_d;
   logic [M-1:0] addr_inc;

   function automatic logic [N-1:0] rst_val(input int idx);
      if (idx == 0) return N'(INIT0);
      if (idx == 1) return N'(INIT1);
      return '0;
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= rst_val(i);
      end else if (bus.Reg_Write) begin
         regs_q[bus.Reg_write_ad] <= bus.Reg_write_data;
      end
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         assign bus.Reg_read_data_1 =
            (bus.Reg_Write && (bus.Reg_read_ad_1 == bus.Reg_write_ad)) ?
            bus.Reg_write_data : regs_q[bus.Reg_read_ad_1];
         assign bus.Reg_read_data_2 =
            (bus.Reg_Write && (bus.Reg_read_ad_2 == bus.Reg_write_ad)) ?
            bus.Reg_write_data : regs_q[bus.Reg_read_ad_2];
      end else begin : g_no_bypass
         assign bus.Reg_read_data_1 = regs_q[bus.Reg_read_ad_1];
         assign bus.Reg_read_data_2 = regs_q[bus.Reg_read_ad_2];
      end
   endgenerate

   // Sampled from stored state, so a same-edge write to inr is not observed.
   always_ff @(posedge Clock) begin
      if (Reset)              outvalue_q <= '0;
      else if (bus.inr_check) outvalue_q <= regs_q[bus.inr];
   end

   assign addr_inc = addr_q + M'(1);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.dump_start) begin
               state_d = S_SEND;
               addr_d  = '0;
               data_d  = regs_q[0];
            end
         end
         S_SEND: begin
            if (bus.dump_ready) begin
               if (&addr_q) begin
                  state_d = S_IDLE;
               end else begin
                  addr_d = addr_inc;
                  data_d = regs_q[addr_inc];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign bus.outvalue   = outvalue_q;
   assign bus.dump_valid = (state_q == S_SEND);
   assign bus.dump_busy  = (state_q == S_SEND);
   assign bus.dump_addr  = addr_q;
   assign bus.dump_data  = data_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_param
//  Brief    : Self-checking bench: BYPASS=1 and BYPASS=0 instances side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_param;
   localparam int N = 16;
   localparam int M = 3;

   logic Clock;
   logic Reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   reg_file_param_if #(.N(N), .M(M)) bus  ();
   reg_file_param_if #(.N(N), .M(M)) bus0 ();

   reg_file_param #(.N(N), .M(M), .BYPASS(1), .INIT0(7), .INIT1(3)) dut_byp (
      .Clock(Clock), .Reset(Reset), .bus(bus.slave));
   reg_file_param #(.N(N), .M(M), .BYPASS(0), .INIT0(7), .INIT1(3)) dut_nobyp (
      .Clock(Clock), .Reset(Reset), .bus(bus0.slave));

   assign bus0.Reg_read_ad_1  = bus.Reg_read_ad_1;
   assign bus0.Reg_read_ad_2  = bus.Reg_read_ad_2;
   assign bus0.Reg_Write      = bus.Reg_Write;
   assign bus0.Reg_write_ad   = bus.Reg_write_ad;
   assign bus0.Reg_write_data = bus.Reg_write_data;
   assign bus0.inr_check      = bus.inr_check;
   assign bus0.inr            = bus.inr;
   assign bus0.dump_start     = bus.dump_start;
   assign bus0.dump_ready     = bus.dump_ready;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: register contents, expected sample, and dump progress
   logic [N-1:0] mem [8];
   logic [N-1:0] old [8];
   logic [N-1:0] out_exp;
   bit           dmp_on;
   int           dmp_idx;
   logic [N-1:0] dmp_val;
   bit           m_ok = 0;

   always @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) mem[i] = '0;
         mem[0] = 16'd7;
         mem[1] = 16'd3;
         out_exp = '0;
         dmp_on  = 0;
         dmp_idx = 0;
         dmp_val = '0;
         m_ok    = 1;
      end else if (m_ok) begin
         for (int i = 0; i < 8; i++) old[i] = mem[i];
         if (bus.inr_check) out_exp = old[bus.inr];
         if (!dmp_on) begin
            if (bus.dump_start) begin
               dmp_on  = 1;
               dmp_idx = 0;
               dmp_val = old[0];
            end
         end else if (bus.dump_ready) begin
            if (dmp_idx == 7) dmp_on = 0;
            else begin
               dmp_idx = dmp_idx + 1;
               dmp_val = old[dmp_idx];
            end
         end
         if (bus.Reg_Write) mem[bus.Reg_write_ad] = bus.Reg_write_data;
      end
   end

   always @(negedge Clock) begin
      if (m_ok) begin
         logic [N-1:0] e1, e2;
         e1 = (bus.Reg_Write && bus.Reg_read_ad_1 == bus.Reg_write_ad) ? bus.Reg_write_data : mem[bus.Reg_read_ad_1];
         e2 = (bus.Reg_Write && bus.Reg_read_ad_2 == bus.Reg_write_ad) ? bus.Reg_write_data : mem[bus.Reg_read_ad_2];
         chk("rd1_byp",    32'(bus.Reg_read_data_1),  32'(e1));
         chk("rd2_byp",    32'(bus.Reg_read_data_2),  32'(e2));
         chk("rd1_nobyp",  32'(bus0.Reg_read_data_1), 32'(mem[bus.Reg_read_ad_1]));
         chk("rd2_nobyp",  32'(bus0.Reg_read_data_2), 32'(mem[bus.Reg_read_ad_2]));
         chk("outvalue",   32'(bus.outvalue),   32'(out_exp));
         chk("outvalue0",  32'(bus0.outvalue),  32'(out_exp));
         chk("dump_valid", 32'(bus.dump_valid), 32'(dmp_on));
         chk("dump_busy",  32'(bus.dump_busy),  32'(dmp_on));
         chk("dump_addr",  32'(bus.dump_addr),  32'(dmp_idx));
         chk("dump_data",  32'(bus.dump_data),  32'(dmp_val));
         chk("dump_data0", 32'(bus0.dump_data), 32'(dmp_val));
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      int cyc, k;
      Reset = 1'b1;
      bus.Reg_read_ad_1 = '0; bus.Reg_read_ad_2 = '0;
      bus.Reg_Write = 1'b0; bus.Reg_write_ad = '0; bus.Reg_write_data = '0;
      bus.inr_check = 1'b0; bus.inr = '0;
      bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
      tick();
      Reset = 1'b0;

      // Reset contents pinned by literals
      for (int a = 0; a < 8; a++) begin
         bus.Reg_read_ad_1 = 3'(a);
         bus.Reg_read_ad_2 = 3'(7 - a);
         #1;
         chk("reset_rd1", 32'(bus.Reg_read_data_1), (a == 0) ? 32'd7 : (a == 1) ? 32'd3 : 32'd0);
         chk("reset_rd2", 32'(bus.Reg_read_data_2), (a == 7) ? 32'd7 : (a == 6) ? 32'd3 : 32'd0);
         tick();
      end
      chk("reset_outvalue", 32'(bus.outvalue), 32'd0);
      chk("reset_valid",    32'(bus.dump_valid), 32'd0);

      // Write-to-read bypass
      bus.Reg_Write = 1'b1; bus.Reg_write_ad = 3'd5; bus.Reg_write_data = 16'hABCD;
      bus.Reg_read_ad_1 = 3'd5; bus.Reg_read_ad_2 = 3'd5;
      #1;
      chk("bypass_on",  32'(bus.Reg_read_data_1),  32'h0000ABCD);
      chk("bypass_on2", 32'(bus.Reg_read_data_2),  32'h0000ABCD);
      chk("bypass_off", 32'(bus0.Reg_read_data_1), 32'h00000000);
      tick();
      bus.Reg_Write = 1'b0;
      #1;
      chk("bypass_off_next", 32'(bus0.Reg_read_data_1), 32'h0000ABCD);

      // Debug sample sees the pre-write value
      bus.Reg_Write = 1'b1; bus.Reg_write_data = 16'h1234;
      bus.inr = 3'd5; bus.inr_check = 1'b1;
      tick();
      chk("sample_prewrite", 32'(bus.outvalue), 32'h0000ABCD);
      bus.Reg_Write = 1'b0;
      tick();
      chk("sample_next", 32'(bus.outvalue), 32'h00001234);
      bus.inr_check = 1'b0; bus.Reg_Write = 1'b1; bus.Reg_write_data = 16'h0F0F;
      tick();
      bus.Reg_Write = 1'b0;
      tick();
      chk("sample_hold", 32'(bus.outvalue), 32'h00001234);

      // Full dump with ready tied high
      bus.Reg_Write = 1'b1; bus.Reg_write_ad = 3'd7; bus.Reg_write_data = 16'hBEEF;
      tick();
      bus.Reg_Write = 1'b0;
      bus.dump_ready = 1'b1; bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      cyc = 1; k = 0;
      while (bus.dump_busy && cyc < 40) begin
         chk("dump_seq_addr", 32'(bus.dump_addr), 32'(k));
         k++;
         tick();
         cyc++;
      end
      chk("dump_beats",  32'(k),   32'd8);
      chk("dump_cycles", 32'(cyc), 32'd9);
      chk("dump_last_data", 32'(bus.dump_data), 32'h0000BEEF);

      // Stall on beat 2 while writing addresses 2 and 3
      bus.dump_ready = 1'b0; bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0; bus.dump_ready = 1'b1;
      tick();
      tick();
      bus.dump_ready = 1'b0;
      bus.Reg_Write = 1'b1; bus.Reg_write_ad = 3'd2; bus.Reg_write_data = 16'h5555;
      tick();
      chk("stall_addr", 32'(bus.dump_addr), 32'd2);
      chk("stall_data", 32'(bus.dump_data), 32'd0);
      bus.Reg_write_ad = 3'd3; bus.Reg_write_data = 16'h7777;
      tick();
      chk("stall_data2", 32'(bus.dump_data), 32'd0);
      bus.Reg_Write = 1'b0;
      tick();
      chk("stall_data3", 32'(bus.dump_data), 32'd0);
      bus.dump_ready = 1'b1;
      tick();
      chk("beat3_addr", 32'(bus.dump_addr), 32'd3);
      chk("beat3_data", 32'(bus.dump_data), 32'h00007777);
      tick();
      chk("beat4_addr", 32'(bus.dump_addr), 32'd4);

      // Reset mid-dump aborts and restores INIT values
      bus.dump_ready = 1'b0; Reset = 1'b1;
      tick();
      Reset = 1'b0;
      bus.Reg_read_ad_1 = 3'd0; bus.Reg_read_ad_2 = 3'd2;
      #1;
      chk("abort_valid", 32'(bus.dump_valid), 32'd0);
      chk("abort_busy",  32'(bus.dump_busy),  32'd0);
      chk("abort_reg0",  32'(bus.Reg_read_data_1), 32'd7);
      chk("abort_reg2",  32'(bus.Reg_read_data_2), 32'd0);
      bus.dump_start = 1'b1; bus.dump_ready = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      chk("restart_valid", 32'(bus.dump_valid), 32'd1);
      chk("restart_addr",  32'(bus.dump_addr),  32'd0);
      chk("restart_data",  32'(bus.dump_data),  32'd7);
      cyc = 0;
      while (bus.dump_busy && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("restart_done", 32'(bus.dump_busy), 32'd0);
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
